// File: rtl/triangle_setup_unit.sv
// Triangle setup: signed doubled area, cull/reorient, clipped bounding box and
// edge coefficients for one triangle at a time, handed off on valid/ready.
module triangle_setup_unit #(
  parameter int unsigned SCREEN_W      = 640,
  parameter int unsigned SCREEN_H      = 480,
  parameter bit          CULL_BACKFACE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] p1 [3],
  input  logic [31:0] p2 [3],
  input  logic [31:0] p3 [3],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p1 [3],
  output logic [31:0] out_p2 [3],
  output logic [31:0] out_p3 [3],
  output logic [15:0] bb_xmin,
  output logic [15:0] bb_xmax,
  output logic [15:0] bb_ymin,
  output logic [15:0] bb_ymax,
  output logic [31:0] edge_a [3],
  output logic [31:0] edge_b [3],
  output logic [63:0] edge_c [3],
  output logic [63:0] area2,
  output logic [31:0] tri_in_count,
  output logic [31:0] tri_cull_count
);

  localparam int unsigned CW    = 16;
  localparam int unsigned DW    = CW + 1;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned AW    = 64;
  localparam int unsigned EW    = 32;
  localparam int unsigned NW    = 32;
  localparam int          XLAST = int'(SCREEN_W) - 1;
  localparam int          YLAST = int'(SCREEN_H) - 1;

  typedef enum logic [2:0] {IDLE, AREA, DECIDE, EDGE, OUTPUT} state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [1:0]           k_q;
  logic [31:0]          v1_q [3];
  logic [31:0]          v2_q [3];
  logic [31:0]          v3_q [3];
  logic [31:0]          o1_q [3];
  logic [31:0]          o2_q [3];
  logic [31:0]          o3_q [3];
  logic signed [AW-1:0] area_raw_q;
  logic signed [AW-1:0] area2_q;
  logic [CW-1:0]        bb_xmin_q, bb_xmax_q, bb_ymin_q, bb_ymax_q;
  logic [EW-1:0]        ea_q [3];
  logic [EW-1:0]        eb_q [3];
  logic [AW-1:0]        ec_q [3];
  logic [NW-1:0]        in_cnt_q;
  logic [NW-1:0]        cull_cnt_q;

  logic signed [CW-1:0] x1, y1, x2, y2, x3, y3;
  logic signed [CW-1:0] xa, ya, xb, yb;
  logic signed [CW-1:0] xmin, xmax, ymin, ymax;
  logic signed [DW-1:0] m0a, m0b, m1a, m1b;
  logic signed [PW-1:0] prod0, prod1;
  logic signed [AW-1:0] mul_diff;
  logic                 flip, offscreen, drop;

  assign x1 = v1_q[0][CW-1:0];
  assign y1 = v1_q[1][CW-1:0];
  assign x2 = v2_q[0][CW-1:0];
  assign y2 = v2_q[1][CW-1:0];
  assign x3 = v3_q[0][CW-1:0];
  assign y3 = v3_q[1][CW-1:0];

  // Edge k endpoints, taken from the reoriented vertices.
  always_comb begin
    xa = o1_q[0][CW-1:0];
    ya = o1_q[1][CW-1:0];
    xb = o2_q[0][CW-1:0];
    yb = o2_q[1][CW-1:0];
    case (k_q)
      2'd1: begin
        xa = o2_q[0][CW-1:0];
        ya = o2_q[1][CW-1:0];
        xb = o3_q[0][CW-1:0];
        yb = o3_q[1][CW-1:0];
      end
      2'd2: begin
        xa = o3_q[0][CW-1:0];
        ya = o3_q[1][CW-1:0];
        xb = o1_q[0][CW-1:0];
        yb = o1_q[1][CW-1:0];
      end
      default: ;
    endcase
  end

  // Shared m0a*m0b - m1a*m1b datapath: area in AREA, edge constant in EDGE.
  always_comb begin
    m0a = DW'(xa);
    m0b = DW'(yb);
    m1a = DW'(ya);
    m1b = DW'(xb);
    if (state_q == AREA) begin
      m0a = DW'(x2) - DW'(x1);
      m0b = DW'(y3) - DW'(y1);
      m1a = DW'(x3) - DW'(x1);
      m1b = DW'(y2) - DW'(y1);
    end
  end

  assign prod0    = PW'(m0a) * PW'(m0b);
  assign prod1    = PW'(m1a) * PW'(m1b);
  assign mul_diff = AW'(prod0) - AW'(prod1);

  // Bounding box is order-independent, so the p2/p3 swap does not affect it.
  always_comb begin
    xmin = x1;
    xmax = x1;
    ymin = y1;
    ymax = y1;
    if (x2 < xmin) xmin = x2;
    if (x3 < xmin) xmin = x3;
    if (x2 > xmax) xmax = x2;
    if (x3 > xmax) xmax = x3;
    if (y2 < ymin) ymin = y2;
    if (y3 < ymin) ymin = y3;
    if (y2 > ymax) ymax = y2;
    if (y3 > ymax) ymax = y3;
  end

  function automatic logic [CW-1:0] clamp(input logic signed [CW-1:0] v, input int hi);
    if (v[CW-1]) return '0;
    if (int'(v) > hi) return CW'(hi);
    return v;
  endfunction

  assign flip      = area_raw_q[AW-1];
  assign offscreen = xmax[CW-1] || ymax[CW-1] || (int'(xmin) > XLAST) || (int'(ymin) > YLAST);
  assign drop      = (area_raw_q == '0) || (flip && CULL_BACKFACE) || offscreen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      k_q         <= '0;
      area_raw_q  <= '0;
      area2_q     <= '0;
      bb_xmin_q   <= '0;
      bb_xmax_q   <= '0;
      bb_ymin_q   <= '0;
      bb_ymax_q   <= '0;
      in_cnt_q    <= '0;
      cull_cnt_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        v1_q[i] <= '0;
        v2_q[i] <= '0;
        v3_q[i] <= '0;
        o1_q[i] <= '0;
        o2_q[i] <= '0;
        o3_q[i] <= '0;
        ea_q[i] <= '0;
        eb_q[i] <= '0;
        ec_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            v1_q       <= p1;
            v2_q       <= p2;
            v3_q       <= p3;
            in_cnt_q   <= in_cnt_q + 32'd1;
            in_ready_q <= 1'b0;
            state_q    <= AREA;
          end
        end
        AREA: begin
          area_raw_q <= mul_diff;
          state_q    <= DECIDE;
        end
        DECIDE: begin
          if (drop) begin
            cull_cnt_q <= cull_cnt_q + 32'd1;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            o1_q <= v1_q;
            if (flip) begin
              o2_q <= v3_q;
              o3_q <= v2_q;
            end else begin
              o2_q <= v2_q;
              o3_q <= v3_q;
            end
            area2_q   <= flip ? -area_raw_q : area_raw_q;
            bb_xmin_q <= clamp(xmin, XLAST);
            bb_xmax_q <= clamp(xmax, XLAST);
            bb_ymin_q <= clamp(ymin, YLAST);
            bb_ymax_q <= clamp(ymax, YLAST);
            k_q       <= 2'd0;
            state_q   <= EDGE;
          end
        end
        EDGE: begin
          ea_q[k_q] <= EW'(ya) - EW'(yb);
          eb_q[k_q] <= EW'(xb) - EW'(xa);
          ec_q[k_q] <= mul_diff;
          if (k_q == 2'd2) begin
            out_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_p1         = o1_q;
  assign out_p2         = o2_q;
  assign out_p3         = o3_q;
  assign bb_xmin        = bb_xmin_q;
  assign bb_xmax        = bb_xmax_q;
  assign bb_ymin        = bb_ymin_q;
  assign bb_ymax        = bb_ymax_q;
  assign edge_a         = ea_q;
  assign edge_b         = eb_q;
  assign edge_c         = ec_q;
  assign area2          = area2_q;
  assign tri_in_count   = in_cnt_q;
  assign tri_cull_count = cull_cnt_q;

endmodule

// File: tb/tb_triangle_setup_unit.sv
// Scoreboard bench for triangle_setup_unit: directed triangles with hand-computed
// setup results, plus a backface-culling instance.
module tb_triangle_setup_unit;

  typedef struct packed {
    logic [31:0]      lat;
    logic [2:0][95:0] v;
    logic [63:0]      bbox;
    logic [2:0][31:0] ea;
    logic [2:0][31:0] eb;
    logic [2:0][63:0] ec;
    logic [63:0]      area;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid2 = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] p1 [3];
  logic [31:0] p2 [3];
  logic [31:0] p3 [3];
  logic [31:0] out_p1 [3], out_p2 [3], out_p3 [3];
  logic [31:0] out2_p1 [3], out2_p2 [3], out2_p3 [3];
  logic [15:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic [15:0] bb2_xmin, bb2_xmax, bb2_ymin, bb2_ymax;
  logic [31:0] edge_a [3], edge_b [3], edge2_a [3], edge2_b [3];
  logic [63:0] edge_c [3], edge2_c [3];
  logic [63:0] area2, area2_2;
  logic [31:0] tri_in_count, tri_cull_count, tri_in_count2, tri_cull_count2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_in = 0;
  int   exp_cull = 0;
  int   ov2_seen = 0;
  bit   seen = 1'b0;
  exp_t sb[$];
  exp_t cur;
  logic [2:0][95:0] gv;
  logic [2:0][31:0] gea, geb;
  logic [2:0][63:0] gec;

  triangle_setup_unit #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACKFACE(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .p1(p1), .p2(p2), .p3(p3), .out_valid(out_valid), .out_ready(out_ready),
    .out_p1(out_p1), .out_p2(out_p2), .out_p3(out_p3),
    .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
    .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c), .area2(area2),
    .tri_in_count(tri_in_count), .tri_cull_count(tri_cull_count)
  );

  triangle_setup_unit #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACKFACE(1'b1)) dut_cull (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .p1(p1), .p2(p2), .p3(p3), .out_valid(out_valid2), .out_ready(1'b1),
    .out_p1(out2_p1), .out_p2(out2_p2), .out_p3(out2_p3),
    .bb_xmin(bb2_xmin), .bb_xmax(bb2_xmax), .bb_ymin(bb2_ymin), .bb_ymax(bb2_ymax),
    .edge_a(edge2_a), .edge_b(edge2_b), .edge_c(edge2_c), .area2(area2_2),
    .tri_in_count(tri_in_count2), .tri_cull_count(tri_cull_count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] vtx(input int x, input int y, input logic [31:0] z);
    return {z, 32'(y), 32'(x)};
  endfunction

  function automatic exp_t mk(input logic [95:0] q1, q2, q3,
                              input int xmn, xmx, ymn, ymx,
                              input int a0, b0, input longint c0,
                              input int a1, b1, input longint c1,
                              input int a2, b2, input longint c2,
                              input longint ar);
    exp_t e;
    e.lat   = '0;
    e.v[0]  = q1;
    e.v[1]  = q2;
    e.v[2]  = q3;
    e.bbox  = {16'(xmn), 16'(xmx), 16'(ymn), 16'(ymx)};
    e.ea[0] = 32'(a0);
    e.ea[1] = 32'(a1);
    e.ea[2] = 32'(a2);
    e.eb[0] = 32'(b0);
    e.eb[1] = 32'(b1);
    e.eb[2] = 32'(b2);
    e.ec[0] = 64'(c0);
    e.ec[1] = 64'(c1);
    e.ec[2] = 64'(c2);
    e.area  = 64'(ar);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic set_p(input logic [95:0] a, b, c);
    p1[0] = a[31:0]; p1[1] = a[63:32]; p1[2] = a[95:64];
    p2[0] = b[31:0]; p2[1] = b[63:32]; p2[2] = b[95:64];
    p3[0] = c[31:0]; p3[1] = c[63:32]; p3[2] = c[95:64];
  endtask

  // Present a triangle, wait (bounded) for in_ready, return the accept edge's cycle.
  task automatic send(input logic [95:0] a, b, c, output int acc);
    int n = 0;
    set_p(a, b, c);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b after %0d cycles", in_ready, n);
    end
    acc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_in++;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic keep_tri(input logic [95:0] a, b, c, input exp_t e);
    int acc;
    send(a, b, c, acc);
    chk("tri_in_count", 64'(tri_in_count), 64'(exp_in));
    e.lat = 32'(acc + 5);
    sb.push_back(e);
    drain();
  endtask

  task automatic drop_tri(input string name, input logic [95:0] a, b, c);
    int acc;
    send(a, b, c, acc);
    chk({name, "_in_ready_e0"}, 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk({name, "_in_ready_e1"}, 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    exp_cull++;
    chk({name, "_in_ready_e2"}, 64'(in_ready), 64'd1);
    chk({name, "_cull_count"}, 64'(tri_cull_count), 64'(exp_cull));
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  // Monitor: compare every cycle out_valid is up, pop on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output out_valid=1 with empty scoreboard (cycle %0d)", cyc);
      end else begin
        cur = sb[0];
        if (!seen) begin
          seen = 1'b1;
          checks++;
          if (cyc != int'(cur.lat)) begin
            errors++;
            $display("FAIL latency got=%0d exp=%0d", cyc, cur.lat);
          end
        end
        gv[0] = {out_p1[2], out_p1[1], out_p1[0]};
        gv[1] = {out_p2[2], out_p2[1], out_p2[0]};
        gv[2] = {out_p3[2], out_p3[1], out_p3[0]};
        for (int i = 0; i < 3; i++) begin
          gea[i] = edge_a[i];
          geb[i] = edge_b[i];
          gec[i] = edge_c[i];
        end
        checks++;
        if (gv !== cur.v) begin
          errors++;
          $display("FAIL out_vertices got=%h exp=%h", gv, cur.v);
        end
        checks++;
        if ({bb_xmin, bb_xmax, bb_ymin, bb_ymax} !== cur.bbox) begin
          errors++;
          $display("FAIL bbox got=%h exp=%h", {bb_xmin, bb_xmax, bb_ymin, bb_ymax}, cur.bbox);
        end
        checks++;
        if (gea !== cur.ea) begin
          errors++;
          $display("FAIL edge_a got=%h exp=%h", gea, cur.ea);
        end
        checks++;
        if (geb !== cur.eb) begin
          errors++;
          $display("FAIL edge_b got=%h exp=%h", geb, cur.eb);
        end
        checks++;
        if (gec !== cur.ec) begin
          errors++;
          $display("FAIL edge_c got=%h exp=%h", gec, cur.ec);
        end
        checks++;
        if (area2 !== cur.area) begin
          errors++;
          $display("FAIL area2 got=%0h exp=%0h", area2, cur.area);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid2) ov2_seen++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_t1, e_clip, e_edge;
    logic [95:0] t1a, t1b, t1c, cla, clb, clc;
    int acc, rel;

    for (int i = 0; i < 3; i++) begin
      p1[i] = '0;
      p2[i] = '0;
      p3[i] = '0;
    end

    t1a = vtx(0, 0, 32'd7);
    t1b = vtx(32'hABCD000A, 0, 32'd7);
    t1c = vtx(0, 10, 32'd7);
    e_t1 = mk(t1a, t1b, t1c, 0, 10, 0, 10,
              0, 10, 0, -10, -10, 100, 10, 0, 0, 100);

    cla = vtx(-5, -5, 32'd0);
    clb = vtx(700, -5, 32'd0);
    clc = vtx(-5, 500, 32'd0);
    e_clip = mk(cla, clb, clc, 0, 639, 0, 479,
                0, 705, 3525, -505, -705, 349975, 505, 0, 2525, 356025);

    e_edge = mk(vtx(639, 0, 32'd4), vtx(700, 0, 32'd5), vtx(639, 10, 32'd6), 639, 639, 0, 10,
                0, 61, 0, -10, -61, 7000, 10, 0, -6390, 610);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_count", 64'(tri_in_count), 64'd0);
    chk("rst_cull_count", 64'(tri_cull_count), 64'd0);
    chk("rst_area2", area2, 64'd0);
    chk("rst_edge_c1", edge_c[1], 64'd0);
    chk("rst_bb_xmax", 64'(bb_xmax), 64'd0);
    chk("rst_in_ready_cull", 64'(in_ready2), 64'd1);

    // Front-facing triangle; ignored upper bits on x of p2 pass through.
    keep_tri(t1a, t1b, t1c, e_t1);

    // Backfacing triangle gets p2/p3 swapped and identical results.
    keep_tri(vtx(0, 0, 32'd1), vtx(0, 10, 32'd2), vtx(10, 0, 32'd3),
             mk(vtx(0, 0, 32'd1), vtx(10, 0, 32'd3), vtx(0, 10, 32'd2), 0, 10, 0, 10,
                0, 10, 0, -10, -10, 100, 10, 0, 0, 100));

    drop_tri("collinear", vtx(0, 0, 32'd0), vtx(5, 5, 32'd0), vtx(10, 10, 32'd0));
    drop_tri("offscreen", vtx(-20, -20, 32'd0), vtx(-10, -20, 32'd0), vtx(-20, -10, 32'd0));
    drop_tri("right_edge", vtx(640, 0, 32'd0), vtx(650, 0, 32'd0), vtx(640, 10, 32'd0));

    keep_tri(vtx(639, 0, 32'd4), vtx(700, 0, 32'd5), vtx(639, 10, 32'd6), e_edge);
    keep_tri(cla, clb, clc, e_clip);

    // Back-pressure: first triangle held at the output while the next waits.
    out_ready = 1'b0;
    send(t1a, t1b, t1c, acc);
    e_t1.lat = 32'(acc + 5);
    sb.push_back(e_t1);
    set_p(cla, clb, clc);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_in_count", 64'(tri_in_count), 64'(exp_in));
    out_ready = 1'b1;
    rel = cyc;
    send(cla, clb, clc, acc);
    chk("bp_accept_cycle", 64'(acc), 64'(rel + 2));
    e_clip.lat = 32'(acc + 5);
    sb.push_back(e_clip);
    drain();
    chk("bp_in_count_after", 64'(tri_in_count), 64'(exp_in));

    // Reset while the triangle is in EDGE.
    send(t1a, t1b, t1c, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_in = 0;
    exp_cull = 0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_in_count", 64'(tri_in_count), 64'd0);
    chk("midrst_cull_count", 64'(tri_cull_count), 64'd0);
    chk("midrst_area2", area2, 64'd0);
    keep_tri(t1a, t1b, t1c, e_t1);

    // Backface culling instance drops the reversed triangle.
    set_p(vtx(0, 0, 32'd1), vtx(0, 10, 32'd2), vtx(10, 0, 32'd3));
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    chk("cull_in_ready_e0", 64'(in_ready2), 64'd0);
    @(posedge clk); #1;
    chk("cull_in_ready_e1", 64'(in_ready2), 64'd0);
    @(posedge clk); #1;
    chk("cull_in_ready_e2", 64'(in_ready2), 64'd1);
    chk("cull_cull_count", 64'(tri_cull_count2), 64'd1);
    chk("cull_in_count", 64'(tri_in_count2), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("cull_no_output", 64'(ov2_seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
